pc_fetch_ctrl: RTL and testbench

- Program-counter and fetch-sequencing block.
- Acts as the initiator on the branch-target lookup interface: drives a 4-bit LUT index and consumes the combinational D-bit target returned by the PC lookup table.
- Handles sequential increment, absolute (LUT) jumps, relative branches, stall, halt and restart.
- Drives the instruction-memory address for the whole core.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_next.sv | 31 +++
 rtl/pc_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / fetch-sequencing block.
package pc_pkg;

    localparam int LUT_W     = 4;
    localparam int D_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_INC  = 2'd1,
        SEL_ABS  = 2'd2,
        SEL_REL  = 2'd3
    } sel_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC mux and adder; all arithmetic wraps modulo 2**D.
module pc_next
    import pc_pkg::*;
#(
    parameter int D     = D_DEFAULT,
    parameter int OFF_W = 8
) (
    input  sel_t             sel,
    input  logic [D-1:0]     prog_ctr,
    input  logic [D-1:0]     lut_target,
    input  logic [OFF_W-1:0] rel_offset,
    output logic [D-1:0]     next_pc
);

    logic [D-1:0] offset_ext;

    // Sign-extend the offset to PC width; the sum then wraps naturally.
    assign offset_ext = D'($signed(rel_offset));

    always_comb begin
        next_pc = prog_ctr;
        case (sel)
            SEL_HOLD: next_pc = prog_ctr;
            SEL_INC:  next_pc = prog_ctr + {{(D-1){1'b0}}, 1'b1};
            SEL_ABS:  next_pc = lut_target;
            SEL_REL:  next_pc = prog_ctr + offset_ext;
            default:  next_pc = prog_ctr;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: IDLE/RUN/HALTED FSM, next-PC select,
// and a saturating retired-instruction counter.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int D     = D_DEFAULT,
    parameter int OFF_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             abs_jump,
    input  logic             taken,
    input  logic [LUT_W-1:0] jump_sel,
    input  logic             rel_jump,
    input  logic [OFF_W-1:0] rel_offset,
    output logic [LUT_W-1:0] lut_addr,
    input  logic [D-1:0]     lut_target,
    output logic [D-1:0]     prog_ctr,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_t         state_q;
    state_t         next_state;
    sel_t           sel;
    logic           cnt_inc;
    logic           restart;
    logic [D-1:0]   next_pc;
    logic [D-1:0]   pc_q;
    logic [CNT_W-1:0] cnt_q;

    assign lut_addr = jump_sel;

    pc_next #(
        .D     (D),
        .OFF_W (OFF_W)
    ) u_pc_next (
        .sel        (sel),
        .prog_ctr   (pc_q),
        .lut_target (lut_target),
        .rel_offset (rel_offset),
        .next_pc    (next_pc)
    );

    // State, PC and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= next_state;
            if (restart) begin
                pc_q  <= '0;
                cnt_q <= '0;
            end else begin
                pc_q <= next_pc;
                if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Next state; decode inputs are only looked at in RUN so X there is harmless.
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (!stall && halt_req) next_state = HALTED;
            HALTED:  if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // Datapath controls and decoded status outputs.
    always_comb begin
        sel     = SEL_HOLD;
        cnt_inc = 1'b0;
        restart = 1'b0;
        case (state_q)
            IDLE, HALTED: restart = start;
            RUN: begin
                if (!stall) begin
                    cnt_inc = 1'b1;
                    if (halt_req)              sel = SEL_HOLD;
                    else if (abs_jump && taken) sel = SEL_ABS;
                    else if (rel_jump && taken) sel = SEL_REL;
                    else                        sel = SEL_INC;
                end
            end
            default: ;
        endcase
    end

    assign running   = (state_q == RUN);
    assign done      = (state_q == HALTED);
    assign prog_ctr  = pc_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: table-driven scenarios with an
// expected-value queue, plus a narrow-counter instance for saturation.
module tb_pc_fetch_ctrl;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       stall;
        logic       halt;
        logic       abs;
        logic       taken;
        logic [3:0] sel;
        logic       rel;
        logic [7:0] off;
        logic [9:0] pc;
        logic [15:0] cnt;
        logic       run;
        logic       done;
    } row_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        abs_jump = 1'b0;
    logic        taken = 1'b0;
    logic [3:0]  jump_sel = 4'd0;
    logic        rel_jump = 1'b0;
    logic [7:0]  rel_offset = 8'd0;
    logic [3:0]  lut_addr;
    logic [9:0]  lut_target;
    logic [9:0]  prog_ctr;
    logic        running;
    logic        done;
    logic [15:0] cycle_cnt;

    logic [3:0]  lut_addr4;
    logic [9:0]  prog_ctr4;
    logic        running4;
    logic        done4;
    logic [3:0]  cycle_cnt4;

    logic [27:0] exp_q[$];
    logic [3:0]  sat_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // Branch-target table model.
    function automatic logic [9:0] lut_fn(input logic [3:0] idx);
        case (idx)
            4'd2:    lut_fn = 10'd80;
            4'd5:    lut_fn = 10'd7;
            4'd7:    lut_fn = 10'd50;
            4'd9:    lut_fn = 10'd4;
            4'd11:   lut_fn = 10'd20;
            default: lut_fn = 10'(idx) * 10'd3;
        endcase
    endfunction

    assign lut_target = lut_fn(lut_addr);

    pc_fetch_ctrl #(.D(10), .OFF_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .halt_req(halt_req), .abs_jump(abs_jump), .taken(taken),
        .jump_sel(jump_sel), .rel_jump(rel_jump), .rel_offset(rel_offset),
        .lut_addr(lut_addr), .lut_target(lut_target), .prog_ctr(prog_ctr),
        .running(running), .done(done), .cycle_cnt(cycle_cnt)
    );

    pc_fetch_ctrl #(.D(10), .OFF_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .halt_req(halt_req), .abs_jump(abs_jump), .taken(taken),
        .jump_sel(jump_sel), .rel_jump(rel_jump), .rel_offset(rel_offset),
        .lut_addr(lut_addr4), .lut_target(lut_target), .prog_ctr(prog_ctr4),
        .running(running4), .done(done4), .cycle_cnt(cycle_cnt4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input row_t r);
        reset      = r.rst;
        start      = r.start;
        stall      = r.stall;
        halt_req   = r.halt;
        abs_jump   = r.abs;
        taken      = r.taken;
        jump_sel   = r.sel;
        rel_jump   = r.rel;
        rel_offset = r.off;
    endtask

    task automatic test_reset();
        row_t rows[3];
        logic [27:0] got, exp;
        rows = '{
            '{1, 0, 0, 0, 0, 0, 4'd0, 0, 8'd0,  10'd0, 16'd0, 0, 0},
            '{1, 1, 0, 0, 1, 1, 4'd2, 0, 8'd0,  10'd0, 16'd0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 4'd3, 0, 8'd0,  10'd0, 16'd0, 0, 0}
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back({rows[i].pc, rows[i].cnt, rows[i].run, rows[i].done});
            tick();
            got = {prog_ctr, cycle_cnt, running, done};
            exp = exp_q.pop_front();
            total_cnt++;
            if (got !== exp)
                $display("FAIL reset row %0d: got pc=%0d cnt=%0d run=%b done=%b, want pc=%0d cnt=%0d run=%b done=%b",
                         i, got[27:18], got[17:2], got[1], got[0], exp[27:18], exp[17:2], exp[1], exp[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_sequential();
        row_t rows[8];
        logic [27:0] got, exp;
        rows = '{
            '{0, 1, 0, 0, 0, 0, 4'd0, 0, 8'd0,  10'd0, 16'd0, 1, 0},
            '{0, 0, 0, 0, 0, 0, 4'd0, 0, 8'd0,  10'd1, 16'd1, 1, 0},
            '{0, 0, 0, 0, 0, 0, 4'd0, 0, 8'd0,  10'd2, 16'd2, 1, 0},
            '{0, 0, 0, 0, 0, 0, 4'd0, 0, 8'd0,  10'd3, 16'd3, 1, 0},
            '{0, 0, 0, 0, 0, 0, 4'd0, 0, 8'd0,  10'd4, 16'd4, 1, 0},
            '{0, 0, 0, 0, 0, 0, 4'd0, 0, 8'd0,  10'd5, 16'd5, 1, 0},
            '{0, 1, 0, 0, 0, 0, 4'd0, 0, 8'd0,  10'd6, 16'd6, 1, 0},
            '{0, 0, 0, 0, 0, 0, 4'd0, 0, 8'd0,  10'd7, 16'd7, 1, 0}
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back({rows[i].pc, rows[i].cnt, rows[i].run, rows[i].done});
            tick();
            got = {prog_ctr, cycle_cnt, running, done};
            exp = exp_q.pop_front();
            total_cnt++;
            if (got !== exp)
                $display("FAIL sequential row %0d: got pc=%0d cnt=%0d run=%b done=%b, want pc=%0d cnt=%0d run=%b done=%b",
                         i, got[27:18], got[17:2], got[1], got[0], exp[27:18], exp[17:2], exp[1], exp[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_abs_jump();
        row_t rows[4];
        logic [27:0] got, exp;
        rows = '{
            '{0, 0, 0, 0, 1, 1, 4'd2, 0, 8'd0,  10'd80, 16'd8,  1, 0},
            '{0, 0, 0, 0, 1, 1, 4'd5, 0, 8'd0,  10'd7,  16'd9,  1, 0},
            '{0, 0, 0, 0, 1, 0, 4'd2, 0, 8'd0,  10'd8,  16'd10, 1, 0},
            '{0, 0, 0, 0, 1, 1, 4'd2, 1, 8'd20, 10'd80, 16'd11, 1, 0}
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            #1;
            total_cnt++;
            if (lut_addr !== rows[i].sel || lut_target !== lut_fn(rows[i].sel))
                $display("FAIL lut_addr row %0d: got addr=%0d target=%0d, want addr=%0d target=%0d",
                         i, lut_addr, lut_target, rows[i].sel, lut_fn(rows[i].sel));
            else pass_cnt++;
            exp_q.push_back({rows[i].pc, rows[i].cnt, rows[i].run, rows[i].done});
            tick();
            got = {prog_ctr, cycle_cnt, running, done};
            exp = exp_q.pop_front();
            total_cnt++;
            if (got !== exp)
                $display("FAIL abs_jump row %0d: got pc=%0d cnt=%0d run=%b done=%b, want pc=%0d cnt=%0d run=%b done=%b",
                         i, got[27:18], got[17:2], got[1], got[0], exp[27:18], exp[17:2], exp[1], exp[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_rel_branch();
        row_t rows[6];
        logic [27:0] got, exp;
        rows = '{
            '{0, 0, 0, 0, 1, 1, 4'd9,  0, 8'd0,   10'd4,    16'd12, 1, 0},
            '{0, 0, 0, 0, 0, 1, 4'd0,  1, 8'hFB,  10'd1023, 16'd13, 1, 0},
            '{0, 0, 0, 0, 0, 0, 4'd0,  0, 8'd0,   10'd0,    16'd14, 1, 0},
            '{0, 0, 0, 0, 1, 1, 4'd11, 0, 8'd0,   10'd20,   16'd15, 1, 0},
            '{0, 0, 0, 0, 0, 1, 4'd0,  1, 8'd20,  10'd40,   16'd16, 1, 0},
            '{0, 0, 0, 0, 0, 0, 4'd0,  1, 8'd20,  10'd41,   16'd17, 1, 0}
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back({rows[i].pc, rows[i].cnt, rows[i].run, rows[i].done});
            tick();
            got = {prog_ctr, cycle_cnt, running, done};
            exp = exp_q.pop_front();
            total_cnt++;
            if (got !== exp)
                $display("FAIL rel_branch row %0d: got pc=%0d cnt=%0d run=%b done=%b, want pc=%0d cnt=%0d run=%b done=%b",
                         i, got[27:18], got[17:2], got[1], got[0], exp[27:18], exp[17:2], exp[1], exp[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall_halt();
        row_t rows[9];
        logic [27:0] got, exp;
        rows = '{
            '{0, 0, 0, 0, 1, 1, 4'd4, 0, 8'd0,  10'd12, 16'd18, 1, 0},
            '{0, 0, 1, 1, 1, 1, 4'd2, 0, 8'd0,  10'd12, 16'd18, 1, 0},
            '{0, 0, 1, 1, 0, 0, 4'd0, 0, 8'd0,  10'd12, 16'd18, 1, 0},
            '{0, 0, 1, 1, 0, 0, 4'd0, 0, 8'd0,  10'd12, 16'd18, 1, 0},
            '{0, 0, 0, 1, 0, 0, 4'd0, 0, 8'd0,  10'd12, 16'd19, 0, 1},
            '{0, 0, 1'bx, 1'bx, 1'bx, 1'bx, 4'd3, 1'bx, 8'hxx, 10'd12, 16'd19, 0, 1},
            '{0, 0, 1'bx, 1'bx, 1'bx, 1'bx, 4'd2, 1'bx, 8'hxx, 10'd12, 16'd19, 0, 1},
            '{0, 1, 0, 0, 0, 0, 4'd0, 0, 8'd0,  10'd0,  16'd0,  1, 0},
            '{0, 0, 0, 0, 0, 0, 4'd0, 0, 8'd0,  10'd1,  16'd1,  1, 0}
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back({rows[i].pc, rows[i].cnt, rows[i].run, rows[i].done});
            tick();
            got = {prog_ctr, cycle_cnt, running, done};
            exp = exp_q.pop_front();
            total_cnt++;
            if (got !== exp)
                $display("FAIL stall_halt row %0d: got pc=%0d cnt=%0d run=%b done=%b, want pc=%0d cnt=%0d run=%b done=%b",
                         i, got[27:18], got[17:2], got[1], got[0], exp[27:18], exp[17:2], exp[1], exp[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_run();
        row_t rows[4];
        logic [27:0] got, exp;
        rows = '{
            '{0, 0, 0, 0, 1, 1, 4'd7, 0, 8'd0,  10'd50, 16'd2, 1, 0},
            '{1, 1, 0, 0, 1, 1, 4'd2, 0, 8'd0,  10'd0,  16'd0, 0, 0},
            '{0, 0, 0, 0, 1, 1, 4'd2, 0, 8'd0,  10'd0,  16'd0, 0, 0},
            '{0, 0, 1'bx, 1'bx, 1'bx, 1'bx, 4'd5, 1'bx, 8'hxx, 10'd0, 16'd0, 0, 0}
        };
        foreach (rows[i]) begin
            drive(rows[i]);
            exp_q.push_back({rows[i].pc, rows[i].cnt, rows[i].run, rows[i].done});
            tick();
            got = {prog_ctr, cycle_cnt, running, done};
            exp = exp_q.pop_front();
            total_cnt++;
            if (got !== exp)
                $display("FAIL reset_mid_run row %0d: got pc=%0d cnt=%0d run=%b done=%b, want pc=%0d cnt=%0d run=%b done=%b",
                         i, got[27:18], got[17:2], got[1], got[0], exp[27:18], exp[17:2], exp[1], exp[0]);
            else pass_cnt++;
        end
    endtask

    // Narrow counter instance must stick at 15; the wide one keeps counting.
    task automatic test_saturation();
        row_t r;
        logic [27:0] got, exp;
        logic [3:0]  sat_exp;
        r = '{1, 0, 0, 0, 0, 0, 4'd0, 0, 8'd0, 10'd0, 16'd0, 0, 0};
        drive(r);
        tick();
        r.rst = 0;
        r.start = 1;
        drive(r);
        tick();
        r.start = 0;
        for (int i = 1; i <= 20; i++) begin
            drive(r);
            exp_q.push_back({10'(i), 16'(i), 1'b1, 1'b0});
            sat_q.push_back((i > 15) ? 4'd15 : 4'(i));
            tick();
            got = {prog_ctr, cycle_cnt, running, done};
            exp = exp_q.pop_front();
            sat_exp = sat_q.pop_front();
            total_cnt++;
            if (got !== exp)
                $display("FAIL saturation_wide cycle %0d: got pc=%0d cnt=%0d, want pc=%0d cnt=%0d",
                         i, got[27:18], got[17:2], exp[27:18], exp[17:2]);
            else pass_cnt++;
            total_cnt++;
            if (cycle_cnt4 !== sat_exp || prog_ctr4 !== exp[27:18])
                $display("FAIL saturation_narrow cycle %0d: got cnt=%0d pc=%0d, want cnt=%0d pc=%0d",
                         i, cycle_cnt4, prog_ctr4, sat_exp, exp[27:18]);
            else pass_cnt++;
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_sequential();
        test_abs_jump();
        test_rel_branch();
        test_stall_halt();
        test_reset_mid_run();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
